// File: rtl/i2c_slave_reg16_dat8_if.sv
// Pad-side I2C lines plus the register-bus port of the 16-bit-address / 8-bit-data I2C target.
// The slave modport is the target's view; the master modport is the pad/register-file side.
interface i2c_slave_reg16_dat8_if;
    logic        i2c_sclk_IN;
    logic        i2c_sdat_IN;
    logic        i2c_sdat_OUT;
    logic        i2c_sdat_OE;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [7:0]  reg_rdata;
    logic        busy;

    modport slave (
        input  i2c_sclk_IN, i2c_sdat_IN, reg_rdata,
        output i2c_sdat_OUT, i2c_sdat_OE, reg_addr, reg_wdata, reg_wr, reg_rd, busy
    );

    modport master (
        output i2c_sclk_IN, i2c_sdat_IN, reg_rdata,
        input  i2c_sdat_OUT, i2c_sdat_OE, reg_addr, reg_wdata, reg_wr, reg_rd, busy
    );
endinterface

// File: rtl/i2c_slave_reg16_dat8.sv
// I2C target for {ID, REG_H, REG_L, DATA...} transactions with burst auto-increment,
// exposing a one-clock-strobe register bus for writes and reads.
module i2c_slave_reg16_dat8 #(
    parameter logic [6:0] DEV_ADDR = 7'h3C,
    parameter int         SYNC_LEN = 2
) (
    input logic                   clk,
    input logic                   rst,
    i2c_slave_reg16_dat8_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_DEVADDR, S_ACK_DEV, S_REG_H, S_ACK_H, S_REG_L,
        S_ACK_L, S_WDATA, S_ACK_W, S_RDATA, S_MACK
    } state_t;

    logic [SYNC_LEN-1:0] scl_sync_q;
    logic [SYNC_LEN-1:0] sda_sync_q;
    logic                scl_prev_q;
    logic                sda_prev_q;

    state_t      state_q;
    logic [3:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic [7:0]  addr_h_q;
    logic [7:0]  tx_q;
    logic        rw_q;
    logic        ack_on_q;
    logic [1:0]  rd_stage_q;
    logic        inc_q;
    logic        oe_q;
    logic [15:0] reg_addr_q;
    logic [7:0]  reg_wdata_q;
    logic        reg_wr_q;
    logic        reg_rd_q;
    logic        busy_q;

    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, sda_rise, sda_fall;
    logic       start_det, stop_det;
    logic [7:0] shift_d;

    assign scl_s     = scl_sync_q[SYNC_LEN-1];
    assign sda_s     = sda_sync_q[SYNC_LEN-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign sda_rise  = sda_s & ~sda_prev_q;
    assign sda_fall  = ~sda_s & sda_prev_q;
    assign start_det = sda_fall & scl_s;
    assign stop_det  = sda_rise & scl_s;
    assign shift_d   = {shift_q[6:0], sda_s};

    // Synchronizers reset to the idle-bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_LEN-2:0], bus.i2c_sclk_IN};
            sda_sync_q <= {sda_sync_q[SYNC_LEN-2:0], bus.i2c_sdat_IN};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            addr_h_q    <= 8'd0;
            tx_q        <= 8'd0;
            rw_q        <= 1'b0;
            ack_on_q    <= 1'b0;
            rd_stage_q  <= 2'd0;
            inc_q       <= 1'b0;
            oe_q        <= 1'b0;
            reg_addr_q  <= 16'd0;
            reg_wdata_q <= 8'd0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            reg_wr_q <= 1'b0;
            reg_rd_q <= 1'b0;
            if (inc_q) begin
                reg_addr_q <= reg_addr_q + 16'd1;
                inc_q      <= 1'b0;
            end

            if (start_det) begin
                state_q    <= S_DEVADDR;
                bit_cnt_q  <= 4'd0;
                oe_q       <= 1'b0;
                ack_on_q   <= 1'b0;
                rd_stage_q <= 2'd0;
            end else if (stop_det) begin
                state_q    <= S_IDLE;
                bit_cnt_q  <= 4'd0;
                oe_q       <= 1'b0;
                ack_on_q   <= 1'b0;
                rd_stage_q <= 2'd0;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: ;
                    S_DEVADDR: if (scl_rise) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (shift_d[7:1] == DEV_ADDR) begin
                                state_q <= S_ACK_DEV;
                                busy_q  <= 1'b1;
                                rw_q    <= shift_d[0];
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    S_REG_H: if (scl_rise) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            addr_h_q <= shift_d;
                            state_q  <= S_ACK_H;
                        end
                    end
                    S_REG_L: if (scl_rise) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            reg_addr_q <= {addr_h_q, shift_d};
                            state_q    <= S_ACK_L;
                        end
                    end
                    // A full data byte is committed only on the falling edge that opens its ACK slot.
                    S_WDATA: begin
                        if (scl_rise && bit_cnt_q != 4'd8) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            reg_wdata_q <= shift_q;
                            reg_wr_q    <= 1'b1;
                            inc_q       <= 1'b1;
                            oe_q        <= 1'b1;
                            ack_on_q    <= 1'b1;
                            bit_cnt_q   <= 4'd0;
                            state_q     <= S_ACK_W;
                        end
                    end
                    // First falling edge pulls SDA low, the next one releases it and moves on.
                    S_ACK_DEV, S_ACK_H, S_ACK_L, S_ACK_W: if (scl_fall) begin
                        if (!ack_on_q) begin
                            oe_q     <= 1'b1;
                            ack_on_q <= 1'b1;
                        end else begin
                            oe_q      <= 1'b0;
                            ack_on_q  <= 1'b0;
                            bit_cnt_q <= 4'd0;
                            case (state_q)
                                S_ACK_DEV: begin
                                    if (rw_q) begin
                                        state_q    <= S_RDATA;
                                        reg_rd_q   <= 1'b1;
                                        rd_stage_q <= 2'd1;
                                    end else begin
                                        state_q <= S_REG_H;
                                    end
                                end
                                S_ACK_H: state_q <= S_REG_L;
                                default: state_q <= S_WDATA;
                            endcase
                        end
                    end
                    S_RDATA: begin
                        if (rd_stage_q == 2'd1) begin
                            tx_q       <= bus.reg_rdata;
                            rd_stage_q <= 2'd2;
                        end else if (rd_stage_q == 2'd2) begin
                            oe_q       <= ~tx_q[7];
                            rd_stage_q <= 2'd0;
                        end
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                oe_q      <= 1'b0;
                                bit_cnt_q <= 4'd0;
                                state_q   <= S_MACK;
                            end else begin
                                oe_q <= ~tx_q[3'd7 - bit_cnt_q[2:0]];
                            end
                        end
                    end
                    S_MACK: begin
                        if (scl_rise) begin
                            if (!sda_s) begin
                                reg_addr_q <= reg_addr_q + 16'd1;
                                ack_on_q   <= 1'b1;
                            end else begin
                                state_q <= S_IDLE;
                                oe_q    <= 1'b0;
                                busy_q  <= 1'b0;
                            end
                        end else if (scl_fall && ack_on_q) begin
                            ack_on_q   <= 1'b0;
                            bit_cnt_q  <= 4'd0;
                            reg_rd_q   <= 1'b1;
                            rd_stage_q <= 2'd1;
                            state_q    <= S_RDATA;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.i2c_sdat_OUT = 1'b0;
    assign bus.i2c_sdat_OE  = oe_q;
    assign bus.reg_addr     = reg_addr_q;
    assign bus.reg_wdata    = reg_wdata_q;
    assign bus.reg_wr       = reg_wr_q;
    assign bus.reg_rd       = reg_rd_q;
    assign bus.busy         = busy_q;
endmodule
